mem_bus_arbiter: RTL and testbench

- Shares the single memory-side line bus (address/data/control to main memory) between two line-level requesters, e.g. two cache instances, or one cache's miss-fill and writeback paths.
- Grants the bus round-robin and sequences the memory protocol: command phase, bus turnaround, wait for response, 8-beat burst.
- Reports per-beat data, completion and timeout back to the granted requester.
- Sits between the cache(s) and the memory model; bidirectional bus tri-stating is done outside the block using mem_drive.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared bus codes, state encoding and default widths for the memory-side line bus arbiter.
package mem_bus_pkg;

   localparam int unsigned ADDR2_BUS_SIZE_DEF = 14;
   localparam int unsigned DATA2_BUS_SIZE_DEF = 16;
   localparam int unsigned CTR2_BUS_SIZE_DEF  = 2;
   localparam int unsigned LINE_BEATS_DEF     = 8;
   localparam int unsigned MEM_TIMEOUT_DEF    = 255;

   localparam logic [1:0] C2_NOP        = 2'd0;
   localparam logic [1:0] C2_RESPONSE   = 2'd1;
   localparam logic [1:0] C2_READ_LINE  = 2'd2;
   localparam logic [1:0] C2_WRITE_LINE = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      TURN,
      WAIT,
      RBURST,
      DONE
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie, the requester that did not win last time is chosen.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       RESET,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_grant ? 2'b01 : 2'b10;
      end
   end

   // Starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (RESET) begin
         last_grant <= 1'b1;
      end else if (take && (gnt != 2'b00)) begin
         last_grant <= gnt[1];
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory line bus between two requesters and sequences
// command, turnaround, response wait and the 8-beat read burst.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned ADDR2_BUS_SIZE = ADDR2_BUS_SIZE_DEF,
   parameter int unsigned DATA2_BUS_SIZE = DATA2_BUS_SIZE_DEF,
   parameter int unsigned CTR2_BUS_SIZE  = CTR2_BUS_SIZE_DEF,
   parameter int unsigned LINE_BEATS     = LINE_BEATS_DEF,
   parameter int unsigned MEM_TIMEOUT    = MEM_TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      RESET,
   input  logic [1:0]                req,
   input  logic [1:0]                cmd_wr,
   input  logic [ADDR2_BUS_SIZE-1:0] addr0,
   input  logic [ADDR2_BUS_SIZE-1:0] addr1,
   input  logic [DATA2_BUS_SIZE-1:0] wdata0,
   input  logic [DATA2_BUS_SIZE-1:0] wdata1,
   output logic [1:0]                gnt,
   output logic [2:0]                beat_idx,
   output logic [DATA2_BUS_SIZE-1:0] rdata,
   output logic                      rvalid,
   output logic                      done,
   output logic                      err,
   output logic [ADDR2_BUS_SIZE-1:0] mem_a,
   output logic [CTR2_BUS_SIZE-1:0]  mem_c_out,
   output logic [DATA2_BUS_SIZE-1:0] mem_d_out,
   output logic                      mem_drive,
   input  logic [CTR2_BUS_SIZE-1:0]  mem_c_in,
   input  logic [DATA2_BUS_SIZE-1:0] mem_d_in
);

   localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [2:0]  LAST_BEAT = 3'(LINE_BEATS - 1);
   localparam logic [CTR2_BUS_SIZE-1:0] C_NOP   = CTR2_BUS_SIZE'(C2_NOP);
   localparam logic [CTR2_BUS_SIZE-1:0] C_RESP  = CTR2_BUS_SIZE'(C2_RESPONSE);
   localparam logic [CTR2_BUS_SIZE-1:0] C_READ  = CTR2_BUS_SIZE'(C2_READ_LINE);
   localparam logic [CTR2_BUS_SIZE-1:0] C_WRITE = CTR2_BUS_SIZE'(C2_WRITE_LINE);

   state_e           state;
   logic             cmd_is_wr;
   logic             sel;
   logic [TMO_W-1:0] tmo_cnt;
   logic [1:0]       arb_gnt;
   logic             take;

   assign take = (state == IDLE) && (req != 2'b00);

   rr_arbiter2 u_arb (
      .clk   (clk),
      .RESET (RESET),
      .req   (req),
      .take  (take),
      .gnt   (arb_gnt)
   );

   // The requester presents wdata for the beat_idx it sees, so forward it in the same cycle.
   assign mem_d_out = ((state == CMD) && cmd_is_wr) ? (sel ? wdata1 : wdata0) : '0;

   always_ff @(posedge clk) begin
      if (RESET) begin
         state     <= IDLE;
         gnt       <= 2'b00;
         rvalid    <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_drive <= 1'b0;
         mem_c_out <= C_NOP;
         mem_a     <= '0;
         beat_idx  <= 3'd0;
         rdata     <= '0;
         cmd_is_wr <= 1'b0;
         sel       <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         rvalid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (take) begin
                  gnt       <= arb_gnt;
                  sel       <= arb_gnt[1];
                  cmd_is_wr <= arb_gnt[1] ? cmd_wr[1] : cmd_wr[0];
                  mem_a     <= arb_gnt[1] ? addr1 : addr0;
                  mem_c_out <= (arb_gnt[1] ? cmd_wr[1] : cmd_wr[0]) ? C_WRITE : C_READ;
                  mem_drive <= 1'b1;
                  beat_idx  <= 3'd0;
                  state     <= CMD;
               end
            end
            CMD: begin
               if (!cmd_is_wr || (beat_idx == LAST_BEAT)) begin
                  mem_drive <= 1'b0;
                  mem_c_out <= C_NOP;
                  beat_idx  <= 3'd0;
                  state     <= TURN;
               end else begin
                  beat_idx <= beat_idx + 3'd1;
               end
            end
            TURN: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (mem_c_in == C_RESP) begin
                  if (cmd_is_wr) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     rdata    <= mem_d_in;
                     rvalid   <= 1'b1;
                     beat_idx <= 3'd1;
                     state    <= RBURST;
                  end
               end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT)) begin
                  done  <= 1'b1;
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            RBURST: begin
               rdata  <= mem_d_in;
               rvalid <= 1'b1;
               if (beat_idx == LAST_BEAT) begin
                  beat_idx <= 3'd0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  beat_idx <= beat_idx + 3'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               err   <= 1'b0;
               gnt   <= 2'b00;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of whole transactions plus hand-written
// sequences for pending round-robin, timeout and reset mid-burst.
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam logic [15:0] WBASE0 = 16'h00B0;
   localparam logic [15:0] WBASE1 = 16'h00A0;
   localparam int          TB_TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        RESET;
   logic [1:0]  req, cmd_wr;
   logic [13:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic [1:0]  gnt;
   logic [2:0]  beat_idx;
   logic [15:0] rdata;
   logic        rvalid, done, err;
   logic [13:0] mem_a;
   logic [1:0]  mem_c_out, mem_c_in;
   logic [15:0] mem_d_out, mem_d_in;
   logic        mem_drive;

   int checks = 0;
   int errors = 0;
   int overlaps = 0;

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  wr;
      logic [13:0] a0;
      logic [13:0] a1;
      int          delay;
      logic [15:0] base;
      logic [1:0]  exp_gnt;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   assign wdata0 = WBASE0 + {13'd0, beat_idx};
   assign wdata1 = WBASE1 + {13'd0, beat_idx};

   mem_bus_arbiter dut (
      .clk       (clk),
      .RESET     (RESET),
      .req       (req),
      .cmd_wr    (cmd_wr),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt       (gnt),
      .beat_idx  (beat_idx),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .done      (done),
      .err       (err),
      .mem_a     (mem_a),
      .mem_c_out (mem_c_out),
      .mem_d_out (mem_d_out),
      .mem_drive (mem_drive),
      .mem_c_in  (mem_c_in),
      .mem_d_in  (mem_d_in)
   );

   // Bus contention: block driving while memory answers.
   always @(posedge clk) begin
      #1;
      if (mem_drive && (mem_c_in == C2_RESPONSE)) overlaps++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string name);
      check(name, {gnt, rvalid, done, err, mem_drive, mem_c_out, mem_a, mem_d_out, beat_idx, rdata},
            {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, C2_NOP, 14'd0, 16'd0, 3'd0, 16'd0});
   endtask

   task automatic do_reset();
      RESET    = 1'b1;
      req      = 2'b00;
      cmd_wr   = 2'b00;
      addr0    = 14'd0;
      addr1    = 14'd0;
      mem_c_in = C2_NOP;
      mem_d_in = 16'd0;
      repeat (2) @(negedge clk);
      RESET = 1'b0;
   endtask

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gnt != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL grant_wait: gnt stayed %0h, required a grant within 20 cycles", gnt);
      end
   endtask

   // Entered at the negedge of the first CMD cycle; leaves at the negedge of DONE.
   task automatic do_mem(input logic wr, input int delay, input logic [15:0] base,
                         input logic [15:0] wbase, input int abort_at);
      if (wr) begin
         for (int k = 0; k < 8; k++) begin
            check("wr_cmd", {mem_drive, mem_c_out, beat_idx}, {1'b1, C2_WRITE_LINE, 3'(k)});
            check("wr_data", mem_d_out, wbase + 16'(k));
            @(negedge clk);
         end
      end else begin
         check("rd_cmd", {mem_drive, mem_c_out}, {1'b1, C2_READ_LINE});
         @(negedge clk);
      end
      check("turn", {mem_drive, mem_c_out}, {1'b0, C2_NOP});
      @(negedge clk);
      for (int i = 1; i < delay; i++) @(negedge clk);
      check("wait_bus", {mem_drive, rvalid, done}, 3'b000);
      mem_c_in = C2_RESPONSE;
      mem_d_in = base;
      if (!wr) begin
         for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            mem_c_in = C2_NOP;
            check("rd_beat", {rvalid, rdata, beat_idx, mem_drive},
                  {1'b1, base + 16'(k - 1), 3'(k), 1'b0});
            if (k == abort_at) begin
               RESET = 1'b1;
               return;
            end
            mem_d_in = base + 16'(k);
         end
      end
      @(negedge clk);
      mem_c_in = C2_NOP;
      if (!wr) check("rd_last", {rvalid, rdata}, {1'b1, base + 16'd7});
      check("done", {done, err}, 2'b10);
   endtask

   task automatic run_txn(input vec_t v);
      bit   ok;
      logic wr;
      addr0  = v.a0;
      addr1  = v.a1;
      cmd_wr = v.wr;
      req    = v.req;
      wait_gnt(ok);
      if (!ok) begin
         req = 2'b00;
         return;
      end
      check("gnt", gnt, v.exp_gnt);
      check("addr", mem_a, v.exp_gnt[1] ? v.a1 : v.a0);
      wr = v.exp_gnt[1] ? v.wr[1] : v.wr[0];
      do_mem(wr, v.delay, v.base, v.exp_gnt[1] ? WBASE1 : WBASE0, 0);
      check("gnt_in_done", gnt, v.exp_gnt);
      req = 2'b00;
      @(negedge clk);
      check("release", {gnt, done, err}, 4'b0000);
   endtask

   initial begin
      bit ok;
      int drv;
      int early;
      int late_done;

      tbl[0] = '{req: 2'b01, wr: 2'b00, a0: 14'h0123, a1: 14'h0000, delay: 4, base: 16'h1000,
                 exp_gnt: 2'b01};
      tbl[1] = '{req: 2'b10, wr: 2'b10, a0: 14'h0000, a1: 14'h3FFF, delay: 3, base: 16'h0000,
                 exp_gnt: 2'b10};
      tbl[2] = '{req: 2'b11, wr: 2'b00, a0: 14'h0555, a1: 14'h2AAA, delay: 1, base: 16'h2000,
                 exp_gnt: 2'b01};
      tbl[3] = '{req: 2'b11, wr: 2'b11, a0: 14'h0111, a1: 14'h0222, delay: 2, base: 16'h0000,
                 exp_gnt: 2'b10};
      tbl[4] = '{req: 2'b11, wr: 2'b01, a0: 14'h1234, a1: 14'h0333, delay: 5, base: 16'h0000,
                 exp_gnt: 2'b01};
      tbl[5] = '{req: 2'b10, wr: 2'b00, a0: 14'h0000, a1: 14'h1ABC, delay: 2, base: 16'h3000,
                 exp_gnt: 2'b10};

      do_reset();
      check_reset_vals("reset_state");

      foreach (tbl[i]) run_txn(tbl[i]);

      // Tie after reset with both held: 0 first, then 1 after a single idle cycle.
      do_reset();
      addr0  = 14'h0AAA;
      addr1  = 14'h1555;
      cmd_wr = 2'b00;
      req    = 2'b11;
      wait_gnt(ok);
      check("tie_first", gnt, 2'b01);
      do_mem(1'b0, 2, 16'h4000, WBASE0, 0);
      @(negedge clk);
      check("tie_gap", {gnt, done}, 3'b000);
      @(negedge clk);
      check("tie_second", {gnt, mem_a}, {2'b10, 14'h1555});
      do_mem(1'b0, 3, 16'h5000, WBASE1, 0);
      req = 2'b00;
      @(negedge clk);
      check("tie_release", gnt, 2'b00);

      // Timeout: memory stays silent.
      addr0  = 14'h0042;
      cmd_wr = 2'b00;
      req    = 2'b01;
      wait_gnt(ok);
      @(negedge clk);
      @(negedge clk);
      drv   = 0;
      early = 0;
      for (int i = 0; i < TB_TIMEOUT + 1; i++) begin
         if (mem_drive) drv++;
         if (done) early++;
         @(negedge clk);
      end
      check("timeout_done", {done, err}, 2'b11);
      check("timeout_drive", drv, 0);
      check("timeout_early", early, 0);
      req = 2'b00;
      @(negedge clk);
      check("timeout_clear", {gnt, done, err}, 4'b0000);

      // Reset at beat 3 of a read burst.
      addr0  = 14'h0777;
      cmd_wr = 2'b00;
      req    = 2'b01;
      wait_gnt(ok);
      do_mem(1'b0, 2, 16'h6000, WBASE0, 3);
      req      = 2'b00;
      mem_c_in = C2_NOP;
      @(negedge clk);
      check_reset_vals("midburst_reset");
      RESET     = 1'b0;
      late_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) late_done++;
      end
      check("midburst_no_done", late_done, 0);
      run_txn('{req: 2'b01, wr: 2'b00, a0: 14'h0999, a1: 14'h0000, delay: 3, base: 16'h7000,
                exp_gnt: 2'b01});

      check("bus_overlap", overlaps, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
